video_stream_timing: RTL and testbench



---
 rtl/video_stream_timing.sv | 161 ++++++++++++++++
 tb/tb_video_stream_timing.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_timing.sv
// Raster timing generator that pulls RGB888 pixels from a valid/ready stream,
// recovering frame alignment from the start-of-frame flag.
module video_stream_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        pixclk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        locked,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEGIN   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEGIN   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        SEEK       = 2'd0,
        WAIT_FRAME = 2'd1,
        LOCKED     = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic          active_s;
    logic          origin_s;
    logic          hs_act_s;
    logic          vs_act_s;
    logic          ready_s;
    logic          take_s;
    logic          uf_s;

    // Raster position decode from the current counter value
    always_comb begin
        active_s = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);
        origin_s = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
        hs_act_s = (h_cnt_r >= HS_BEGIN) && (h_cnt_r < HS_END);
        vs_act_s = (v_cnt_r >= VS_BEGIN) && (v_cnt_r < VS_END);
    end

    // Alignment FSM: ready generation, pixel take and next-state decision
    always_comb begin
        ready_s     = 1'b0;
        take_s      = 1'b0;
        uf_s        = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            SEEK: begin
                // Non-SOF beats are drained; the SOF beat stays at the head
                ready_s = ~s_sof;
                if (s_valid && s_sof) begin
                    state_nxt_s = WAIT_FRAME;
                end else begin
                    state_nxt_s = SEEK;
                end
            end
            WAIT_FRAME: begin
                ready_s = origin_s;
                if (origin_s && s_valid) begin
                    if (s_sof) begin
                        take_s      = 1'b1;
                        state_nxt_s = LOCKED;
                    end else begin
                        state_nxt_s = SEEK;
                    end
                end else begin
                    state_nxt_s = WAIT_FRAME;
                end
            end
            LOCKED: begin
                if (!active_s) begin
                    ready_s     = 1'b0;
                    state_nxt_s = LOCKED;
                end else if (!s_valid) begin
                    ready_s     = 1'b1;
                    uf_s        = 1'b1;
                    state_nxt_s = SEEK;
                end else if (s_sof != origin_s) begin
                    // SOF off the origin or a plain beat on it: refuse and realign
                    ready_s     = 1'b0;
                    state_nxt_s = s_sof ? WAIT_FRAME : SEEK;
                end else begin
                    ready_s     = 1'b1;
                    take_s      = 1'b1;
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                ready_s     = 1'b0;
                state_nxt_s = SEEK;
            end
        endcase
    end

    assign s_ready = ready_s & rst_n;

    // Free-running horizontal and vertical counters
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= (v_cnt_r == V_LAST) ? {VW{1'b0}} : v_cnt_r + VW'(1);
        end else begin
            h_cnt_r <= h_cnt_r + HW'(1);
        end
    end

    // State register and the single output stage feeding the TMDS encoders
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r               <= SEEK;
            {red, green, blue}    <= 24'h000000;
            de                    <= 1'b0;
            hsync                 <= ~HS_POL;
            vsync                 <= ~VS_POL;
            locked                <= 1'b0;
            underflow             <= 1'b0;
        end else begin
            state_r               <= state_nxt_s;
            {red, green, blue}    <= take_s ? s_data : 24'h000000;
            de                    <= active_s;
            hsync                 <= hs_act_s ? HS_POL : ~HS_POL;
            vsync                 <= vs_act_s ? VS_POL : ~VS_POL;
            locked                <= (state_nxt_s == LOCKED);
            underflow             <= uf_s;
        end
    end

endmodule

// File: tb/tb_video_stream_timing.sv
// Self-checking bench for video_stream_timing on a reduced raster, with a
// cycle-level reference model derived from absolute cycle time since reset.
module tb_video_stream_timing;

    localparam int   HA  = 8;
    localparam int   HF  = 2;
    localparam int   HSW = 3;
    localparam int   HB  = 2;
    localparam int   VA  = 6;
    localparam int   VF  = 1;
    localparam int   VSW = 2;
    localparam int   VB  = 1;
    localparam int   HT  = HA + HF + HSW + HB;
    localparam int   VT  = VA + VF + VSW + VB;
    localparam int   FT  = HT * VT;
    localparam int   FS  = HA * VA;
    localparam logic HS_P = 1'b1;
    localparam logic VS_P = 1'b0;

    logic        pixclk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_sof;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        locked;
    logic        underflow;

    always #5 pixclk = ~pixclk;

    video_stream_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HS_P), .VS_POL(VS_P)
    ) dut (
        .pixclk(pixclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_sof(s_sof), .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de), .locked(locked), .underflow(underflow)
    );

    int          checks = 0;
    int          failures = 0;
    int          t;          // cycles since reset release
    int          m_mode;     // 0 seek, 1 wait for frame, 2 locked
    int          src_idx;    // position of the head beat within its source frame
    logic [23:0] src_data;
    bit          src_inc;
    int          uf_seen;
    logic [28:0] exp_vec;
    logic [28:0] act_vec;
    logic [28:0] rst_vec;

    task automatic src_advance();
        src_idx  = (src_idx + 1) % FS;
        src_data = src_inc ? src_data + 24'd1 : 24'($urandom);
    endtask

    // One raster cycle: drive the head beat (or not), predict, check, advance.
    task automatic step(input bit vld);
        int          h;
        int          v;
        int          nmode;
        bit          act;
        bit          org;
        bit          e_ready;
        bit          e_uf;
        logic        e_hs;
        logic        e_vs;
        logic [23:0] e_px;
        h   = t % HT;
        v   = (t / HT) % VT;
        act = (h < HA) && (v < VA);
        org = (h == 0) && (v == 0);
        s_valid = vld;
        s_sof   = vld && (src_idx == 0);
        s_data  = vld ? src_data : 24'h000000;
        e_ready = 1'b0;
        e_uf    = 1'b0;
        e_px    = 24'h000000;
        nmode   = m_mode;
        if (m_mode == 0) begin
            e_ready = !s_sof;
            if (s_valid && s_sof) nmode = 1;
        end else if (m_mode == 1) begin
            e_ready = org;
            if (org && s_valid) begin
                if (s_sof) begin
                    e_px  = s_data;
                    nmode = 2;
                end else begin
                    nmode = 0;
                end
            end
        end else if (act) begin
            if (!s_valid) begin
                e_ready = 1'b1;
                e_uf    = 1'b1;
                nmode   = 0;
            end else if (s_sof && !org) begin
                nmode = 1;
            end else if (!s_sof && org) begin
                nmode = 0;
            end else begin
                e_ready = 1'b1;
                e_px    = s_data;
            end
        end
        e_hs = (h >= HA + HF && h < HA + HF + HSW) ? HS_P : ~HS_P;
        e_vs = (v >= VA + VF && v < VA + VF + VSW) ? VS_P : ~VS_P;
        @(negedge pixclk);
        checks++;
        if (s_ready !== e_ready) begin
            failures++;
            $display("FAIL s_ready t=%0d h=%0d v=%0d got=%b exp=%b", t, h, v, s_ready, e_ready);
        end
        @(posedge pixclk);
        #1;
        exp_vec = {e_px, act, e_hs, e_vs, (nmode == 2), e_uf};
        act_vec = {red, green, blue, de, hsync, vsync, locked, underflow};
        checks++;
        if (act_vec !== exp_vec) begin
            failures++;
            $display("FAIL outputs t=%0d h=%0d v=%0d got=%h exp=%h", t, h, v, act_vec, exp_vec);
        end
        if (underflow === 1'b1) uf_seen++;
        if (vld && e_ready) src_advance();
        m_mode = nmode;
        t++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge pixclk);
        #1;
        rst_n  = 1'b1;
        t      = 0;
        m_mode = 0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        s_data  = 24'($urandom);
        rst_vec = {24'h000000, 1'b0, ~HS_P, ~VS_P, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            @(posedge pixclk);
            #1;
            checks++;
            if ({red, green, blue, de, hsync, vsync, locked, underflow} !== rst_vec) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=%h", {red, green, blue, de, hsync, vsync, locked, underflow}, rst_vec);
            end
            checks++;
            if (s_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready got=%b exp=0", s_ready);
            end
        end
        rst_n   = 1'b1;
        s_valid = 1'b0;
        t       = 0;
        m_mode  = 0;
    endtask

    task automatic test_idle_raster();
        int de_cnt = 0;
        int hs_cnt = 0;
        int vs_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            step(1'b0);
            if (de === 1'b1) de_cnt++;
            if (hsync === HS_P) hs_cnt++;
            if (vsync === VS_P) vs_cnt++;
        end
        checks++;
        if (de_cnt != FS) begin
            failures++;
            $display("FAIL idle_de_count got=%0d exp=%0d", de_cnt, FS);
        end
        checks++;
        if (hs_cnt != HSW * VT) begin
            failures++;
            $display("FAIL idle_hsync_count got=%0d exp=%0d", hs_cnt, HSW * VT);
        end
        checks++;
        if (vs_cnt != VSW * HT) begin
            failures++;
            $display("FAIL idle_vsync_count got=%0d exp=%0d", vs_cnt, VSW * HT);
        end
    endtask

    task automatic test_clean_lock();
        int          t0 = -1;
        int          tt;
        logic [23:0] e_pix;
        src_idx  = 0;
        src_data = 24'h000000;
        src_inc  = 1'b1;
        for (int i = 0; i < 4 * FT; i++) begin
            step(1'b1);
            tt = t - 1;
            if (de === 1'b1 && locked === 1'b1) begin
                if (t0 < 0) begin
                    t0 = tt;
                    checks++;
                    if (tt % FT != 0) begin
                        failures++;
                        $display("FAIL first_accept_pos got=%0d exp=0", tt % FT);
                    end
                end
                e_pix = 24'(((tt - t0) / FT) * FS + ((tt / HT) % VT) * HA + (tt % HT));
                checks++;
                if ({red, green, blue} !== e_pix) begin
                    failures++;
                    $display("FAIL clean_pixel t=%0d got=%h exp=%h", tt, {red, green, blue}, e_pix);
                end
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL clean_lock_held got=%b exp=1", locked);
        end
    endtask

    task automatic test_leading_garbage();
        int n = 0;
        do_reset();
        src_inc  = 1'b0;
        src_idx  = FS - 5;
        src_data = 24'($urandom);
        while (src_idx != 0 && n < 20) begin
            step(1'b1);
            n++;
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL garbage_discarded got=%0d exp=5", n);
        end
        for (int i = 0; i < 2 * FT; i++) step(1'b1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL garbage_relock got=%b exp=1", locked);
        end
    endtask

    task automatic test_underflow();
        int n = 0;
        while (!(t % FT == 2 * HT + 3 && m_mode == 2) && n < 3 * FT) begin
            step(1'b1);
            n++;
        end
        checks++;
        if (!(t % FT == 2 * HT + 3 && m_mode == 2)) begin
            failures++;
            $display("FAIL underflow_setup timeout got=%0d exp=%0d", t % FT, 2 * HT + 3);
        end
        uf_seen = 0;
        step(1'b0);
        checks++;
        if ({red, green, blue, underflow, locked} !== {24'h000000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL underflow_pulse got=%h exp=%h", {red, green, blue, underflow, locked}, {24'h000000, 1'b1, 1'b0});
        end
        for (int i = 0; i < 2 * FT; i++) step(1'b1);
        checks++;
        if (uf_seen != 1) begin
            failures++;
            $display("FAIL underflow_count got=%0d exp=1", uf_seen);
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL underflow_relock got=%b exp=1", locked);
        end
    endtask

    task automatic test_misplaced_sof();
        int n = 0;
        while (!(t % FT == 3 * HT + 5 && m_mode == 2) && n < 3 * FT) begin
            step(1'b1);
            n++;
        end
        checks++;
        if (!(t % FT == 3 * HT + 5 && m_mode == 2)) begin
            failures++;
            $display("FAIL misplaced_setup timeout got=%0d exp=%0d", t % FT, 3 * HT + 5);
        end
        src_idx  = 0;
        src_data = 24'($urandom);
        step(1'b1);
        checks++;
        if ({red, green, blue, locked} !== {24'h000000, 1'b0}) begin
            failures++;
            $display("FAIL misplaced_black got=%h exp=%h", {red, green, blue, locked}, {24'h000000, 1'b0});
        end
        for (int i = 0; i < 2 * FT; i++) step(1'b1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL misplaced_relock got=%b exp=1", locked);
        end
    endtask

    task automatic test_random();
        src_inc = 1'b0;
        for (int i = 0; i < 8 * FT; i++) begin
            if ($urandom_range(0, 79) == 0) src_idx = 0;
            step($urandom_range(0, 49) != 0);
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        src_inc = 1'b0;
        while (!(t % FT == 4 * HT + 5 && m_mode == 2) && n < 4 * FT) begin
            step(1'b1);
            n++;
        end
        checks++;
        if (!(t % FT == 4 * HT + 5 && m_mode == 2)) begin
            failures++;
            $display("FAIL midreset_setup timeout got=%0d exp=%0d", t % FT, 4 * HT + 5);
        end
        s_valid = 1'b1;
        s_sof   = 1'b0;
        rst_n   = 1'b0;
        #1;
        checks++;
        if ({red, green, blue, de, hsync, vsync, locked, underflow} !== rst_vec) begin
            failures++;
            $display("FAIL midreset_async got=%h exp=%h", {red, green, blue, de, hsync, vsync, locked, underflow}, rst_vec);
        end
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ready got=%b exp=0", s_ready);
        end
        @(posedge pixclk);
        #1;
        rst_n  = 1'b1;
        t      = 0;
        m_mode = 0;
        step(1'b0);
        checks++;
        if ({de, locked} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_restart got=%b exp=10", {de, locked});
        end
        for (int i = 0; i < 2 * FT; i++) step(1'b1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL midreset_relock got=%b exp=1", locked);
        end
    endtask

    initial begin
        src_idx  = 0;
        src_data = 24'h000000;
        src_inc  = 1'b1;
        uf_seen  = 0;
        test_reset();
        test_idle_raster();
        test_clean_lock();
        test_leading_garbage();
        test_underflow();
        test_misplaced_sof();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
